// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writable instruction memory filled from a byte stream, with a combinational fetch port
// Ports:
//   clk, reset          - system clock, synchronous active-high reset (also clears the memory)
//   start               - one-cycle pulse that opens a load session (honoured in IDLE and DONE)
//   s_valid/s_data/s_last/s_ready - byte-stream load handshake; s_last marks the final program byte
//   A, RD               - fetch byte address and the 32-bit word there (zero for unaligned addresses)
//   busy, done, err     - session in progress / session ended / last session overflowed the memory
//   cpu_hold            - processor held off until a load finishes cleanly
//   word_count          - words committed in the current or last session
module instr_mem_loader #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] A,
    output logic [31:0]       RD,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [6:0]        word_count
);
    localparam int IW = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] mem [DEPTH_WORDS];
    logic [1:0]  bidx;
    logic [23:0] abuf;
    logic [6:0]  wcnt;
    logic        err_q;
    logic        accept, commit, full, restart;
    logic [31:0] word;

    // Only bytes below bidx are held in abuf; it is cleared on every commit, so any
    // byte position not yet received reads as zero in the committed word.
    assign accept  = s_valid & s_ready;
    assign commit  = accept & (bidx == 2'd3 | s_last);
    assign full    = wcnt == 7'(DEPTH_WORDS - 1);
    assign restart = start & (state == IDLE | state == DONE);
    assign word    = {8'h0, abuf} | ({24'h0, s_data} << {bidx, 3'b000});

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = commit & (s_last | full) ? DONE : LOAD;
            DONE:    state_nx = start ? LOAD : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready  = state == LOAD;
        busy     = state == LOAD;
        done     = state == DONE;
        err      = err_q;
        cpu_hold = !(state == DONE && !err_q);
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            bidx  <= '0;
            abuf  <= '0;
            wcnt  <= '0;
            err_q <= 1'b0;
        end else if (commit) begin
            bidx  <= '0;
            abuf  <= '0;
            wcnt  <= wcnt + 7'd1;
            err_q <= ~s_last & full;
        end else if (accept) begin
            bidx  <= bidx + 2'd1;
            abuf  <= word[23:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (commit) begin
            mem[wcnt[IW-1:0]] <= word;
        end
    end

    assign word_count = wcnt;
    assign RD         = A[1:0] == 2'b00 ? mem[A[ADDR_W-1:2]] : 32'h0;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized load sessions checked against a byte-list memory model
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        reset, start, s_valid, s_last;
    logic [7:0]  s_data, A;
    logic [31:0] RD;
    logic        s_ready, busy, done, err, cpu_hold;
    logic [6:0]  word_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_mem [64];
    int          exp_wc;
    bit          exp_err;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .A(A), .RD(RD), .busy(busy), .done(done),
        .err(err), .cpu_hold(cpu_hold), .word_count(word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory image a session should leave: bytes laid little-endian from word 0,
    // a started word zero-filled, at most 256 bytes stored, untouched words kept.
    task automatic model_load(input logic [7:0] q[$], input bit has_last);
        int n;
        n = q.size() > 256 ? 256 : q.size();
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 0) exp_mem[i/4] = 32'h0;
            exp_mem[i/4][8*(i%4) +: 8] = q[i];
        end
        exp_wc  = (n + 3) / 4;
        exp_err = !has_last;
    endtask

    task automatic model_reset();
        for (int w = 0; w < 64; w++) exp_mem[w] = 32'h0;
        exp_wc  = 0;
        exp_err = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int w = 0; w < 64; w++) begin
            A = 8'(w * 4);
            #1;
            chk($sformatf("%s mem[%0d]", tag, w), RD, exp_mem[w]);
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, " word_count"}, 32'(word_count), 32'(exp_wc));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
        chk({tag, " s_ready"}, 32'(s_ready), 32'd0);
    endtask

    task automatic do_start(input string tag);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy after start"}, 32'(busy), 32'd1);
        chk({tag, " word_count after start"}, 32'(word_count), 32'd0);
    endtask

    // Offers each byte until it is taken; stall is the percent chance of withholding s_valid.
    task automatic send(input logic [7:0] q[$], input bit last, input int stall);
        @(posedge clk); #1;
        for (int i = 0; i < q.size(); i++) begin
            bit got = 1'b0;
            int cyc = 0;
            while (!got && cyc < 2000) begin
                s_valid = stall > 0 ? ($urandom_range(0, 99) >= stall) : 1'b1;
                s_data  = q[i];
                s_last  = last && (i == q.size() - 1);
                got     = s_valid && s_ready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!got) begin
                chk("send timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] prog2[$];
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h0; A = 8'h04;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset RD@04", RD, 32'h0);
        chk("reset cpu_hold", 32'(cpu_hold), 32'd1);
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset word_count", 32'(word_count), 32'd0);

        prog2 = '{8'h93, 8'h00, 8'hB0, 8'h0A, 8'h23, 8'h00, 8'h10, 8'h00};
        do_start("two-word");
        send(prog2, 1'b1, 0);
        model_load(prog2, 1'b1);
        check_done("two-word");
        check_mem("two-word");
        A = 8'h00; #1; chk("two-word RD@00", RD, 32'h0AB00093);
        A = 8'h04; #1; chk("two-word RD@04", RD, 32'h00100023);

        q = '{8'h03, 8'h01};
        do_start("partial");
        send(q, 1'b1, 0);
        model_load(q, 1'b1);
        check_done("partial");
        check_mem("partial");
        A = 8'h00; #1; chk("partial RD@00", RD, 32'h00000103);

        do_start("stalled");
        send(prog2, 1'b1, 50);
        model_load(prog2, 1'b1);
        check_done("stalled");
        check_mem("stalled");

        for (int r = 0; r < 3; r++) begin
            q = {};
            repeat ($urandom_range(1, 40)) q.push_back(8'($urandom));
            do_start("random");
            send(q, 1'b1, 30);
            model_load(q, 1'b1);
            check_done($sformatf("random%0d", r));
            check_mem($sformatf("random%0d", r));
        end

        q = {};
        repeat (256) q.push_back(8'($urandom));
        do_start("overflow");
        send(q, 1'b0, 20);
        model_load(q, 1'b0);
        check_done("overflow");
        A = 8'hFC; #1; chk("overflow RD@FC", RD, {q[255], q[254], q[253], q[252]});
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
        chk("overflow 257th s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        check_done("overflow after 257th");
        check_mem("overflow after 257th");

        A = 8'h02; #1; chk("unaligned RD@02", RD, 32'h0);
        q = '{8'hAA};
        do_start("restart");
        send(q, 1'b1, 0);
        model_load(q, 1'b1);
        check_done("restart");
        check_mem("restart");
        A = 8'h00; #1; chk("restart RD@00", RD, 32'h000000AA);

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_start("midload");
        send(q, 1'b0, 0);
        chk("midload busy", 32'(busy), 32'd1);
        chk("midload word_count", 32'(word_count), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("midload reset busy", 32'(busy), 32'd0);
        chk("midload reset done", 32'(done), 32'd0);
        chk("midload reset cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midload reset word_count", 32'(word_count), 32'd0);
        check_mem("midload reset");
        s_valid = 1'b1; s_data = 8'h77;
        chk("idle s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("idle ignores byte", 32'(word_count), 32'd0);
        check_mem("idle ignores byte");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
